// File: rtl/lsu_bus_port_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_bus_port_pkg
// Purpose : Shared encodings and helper functions for the load/store bus port:
//           access sizes, FSM states, exception codes, alignment check,
//           byte-enable generation and store-lane replication.
// Ports   : none (package)
// Options : none here; the top honours LSU_TIMEOUT_EN
// Revision: 1.0 - initial release
// ============================================================================
package lsu_bus_port_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        EXC_NONE = 2'd0,
        EXC_ADEL = 2'd1,
        EXC_ADES = 2'd2
    } exc_e;

    // The reserved size never aligns, so it always takes the exception path.
    function automatic logic is_aligned(input size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return (lane[0] == 1'b0);
            SZ_WORD: return (lane == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the narrow datum lets the byte enables alone pick the lane.
    function automatic logic [31:0] lane_wdata(input size_e sz, input logic [31:0] wd);
        case (sz)
            SZ_BYTE: return {4{wd[7:0]}};
            SZ_HALF: return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_bus_port_if.sv
`default_nettype none
// ============================================================================
// Module  : lsu_bus_port_if
// Purpose : Bundles the M-stage request, data-bus and W-stage response
//           signals of the load/store port.
// Modports: slave  - the port itself (lsu_bus_port)
//           master - the surrounding pipeline plus bus environment
// Revision: 1.0 - initial release
// ============================================================================
interface lsu_bus_port_if;
    // M-stage request
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    // External data bus
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    // W-stage response
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        exc_adel;
    logic        exc_ades;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  bus_ack, bus_rdata,
        output req_ready, stall,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output rsp_valid, rsp_rdata, exc_adel, exc_ades
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output bus_ack, bus_rdata,
        input  req_ready, stall,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  rsp_valid, rsp_rdata, exc_adel, exc_ades
    );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_ext.sv
`default_nettype none
// ============================================================================
// Module  : lsu_lane_ext
// Purpose : Combinational load-lane extractor. Picks the addressed byte or
//           halfword out of a bus word and sign- or zero-extends it to 32 bits;
//           words pass unchanged.
// Ports   : i_rdata  - bus read word
//           i_lane   - byte offset addr[1:0]
//           i_size   - access size
//           i_signed - 1 = sign-extend, 0 = zero-extend
//           o_data   - extended result
// Revision: 1.0 - initial release
// ============================================================================
module lsu_lane_ext
    import lsu_bus_port_pkg::*;
(
    input  wire logic [31:0] i_rdata,
    input  wire logic [1:0]  i_lane,
    input  wire size_e       i_size,
    input  wire logic        i_signed,
    output logic [31:0]      o_data
);

    // Shifting the addressed lane down to bit 0 covers every legal offset.
    logic [15:0] w_shift;

    always_comb begin
        w_shift = 16'(i_rdata >> {i_lane, 3'b000});
        o_data  = i_rdata;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_signed & w_shift[7]}},  w_shift[7:0]};
            SZ_HALF: o_data = {{16{i_signed & w_shift[15]}}, w_shift[15:0]};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_bus_port.sv
`default_nettype none
// ============================================================================
// Module  : lsu_bus_port
// Purpose : Load/store port between the M stage and the external data bus.
//           Places store data on byte lanes with byte enables, runs a
//           registered req/ack handshake, extracts and extends load data,
//           and raises address-error exceptions for misaligned accesses.
// Ports   : clk, reset (synchronous, active high)
//           lsu (lsu_bus_port_if.slave) - request, bus and response signals
// Params  : TIMEOUT_CYCLES - ack-wait limit (only with LSU_TIMEOUT_EN)
// Options : LSU_TIMEOUT_EN - abort a stuck bus transfer with an address error
// Revision: 1.0 - initial release
// ============================================================================
module lsu_bus_port
    import lsu_bus_port_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  wire logic     clk,
    input  wire logic     reset,
    lsu_bus_port_if.slave lsu
);

    state_e      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic        we_q,    we_d;
    logic [3:0]  be_q,    be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  lane_q,  lane_d;
    size_e       size_q,  size_d;
    logic        signed_q, signed_d;
    logic [31:0] rdata_q, rdata_d;
    exc_e        exc_q,   exc_d;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    size_e       w_size;
    logic [1:0]  w_lane;
    logic        w_accept;
    logic        w_aligned;
    logic [31:0] w_ext;

    assign w_size    = size_e'(lsu.req_size);
    assign w_lane    = lsu.req_addr[1:0];
    assign w_accept  = lsu.req_valid && (state_q == ST_IDLE);
    assign w_aligned = is_aligned(w_size, w_lane);

    lsu_lane_ext u_lane_ext (
        .i_rdata  (lsu.bus_rdata),
        .i_lane   (lane_q),
        .i_size   (size_q),
        .i_signed (signed_q),
        .o_data   (w_ext)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        lane_d   = lane_q;
        size_d   = size_q;
        signed_d = signed_q;
        rdata_d  = rdata_q;
        exc_d    = exc_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    we_d     = lsu.req_we;
                    lane_d   = w_lane;
                    size_d   = w_size;
                    signed_d = lsu.req_signed;
                    if (w_aligned) begin
                        state_d = ST_REQ;
                        addr_d  = {lsu.req_addr[31:2], 2'b00};
                        be_d    = byte_en(w_size, w_lane);
                        wdata_d = lane_wdata(w_size, lsu.req_wdata);
                        exc_d   = EXC_NONE;
`ifdef LSU_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        // Misaligned: skip the bus entirely, report at once.
                        state_d = ST_RSP;
                        rdata_d = '0;
                        exc_d   = lsu.req_we ? EXC_ADES : EXC_ADEL;
                    end
                end
            end
            ST_REQ: begin
                if (lsu.bus_ack) begin
                    state_d = ST_RSP;
                    rdata_d = we_q ? 32'd0 : w_ext;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Final allowed wait cycle without ack: abort as bus error.
                    state_d = ST_RSP;
                    rdata_d = '0;
                    exc_d   = we_q ? EXC_ADES : EXC_ADEL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            lane_q   <= '0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            rdata_q  <= '0;
            exc_q    <= EXC_NONE;
`ifdef LSU_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            rdata_q  <= rdata_d;
            exc_q    <= exc_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign lsu.req_ready = (state_q == ST_IDLE);
    assign lsu.stall     = (lsu.req_valid && (state_q != ST_IDLE)) || (state_q == ST_REQ);
    assign lsu.bus_req   = (state_q == ST_REQ);
    assign lsu.bus_we    = we_q;
    assign lsu.bus_addr  = addr_q;
    assign lsu.bus_be    = be_q;
    assign lsu.bus_wdata = wdata_q;
    assign lsu.rsp_valid = (state_q == ST_RSP);
    assign lsu.rsp_rdata = rdata_q;
    // Exception flags are only driven during the response pulse.
    assign lsu.exc_adel  = (state_q == ST_RSP) && (exc_q == EXC_ADEL);
    assign lsu.exc_ades  = (state_q == ST_RSP) && (exc_q == EXC_ADES);

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_bus_port
// Purpose : Self-checking bench for lsu_bus_port: directed operations with a
//           transaction-level expectation model and a per-cycle comparator.
// Options : LSU_TIMEOUT_EN - also exercises the ack timeout with 4 cycles
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu_bus_port;

`ifdef LSU_TIMEOUT_EN
    localparam int TO       = 4;
    localparam int LONG_DLY = 3;
`else
    localparam int TO       = 255;
    localparam int LONG_DLY = 5;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_bus_port_if u_if ();

    lsu_bus_port #(.TIMEOUT_CYCLES(TO)) u_dut (
        .clk   (clk),
        .reset (reset),
        .lsu   (u_if)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Expected per-cycle view of the port
    logic        chk_en;
    logic        m_ready, m_bus_req, m_rsp, m_exl, m_exs, m_we;
    logic [31:0] m_addr, m_wdata, m_hold;
    logic [3:0]  m_be;

    int cyc = 0;
    int acc_cyc = 0;
    int last_lat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- expectation model ----------------
    function automatic logic [3:0] mdl_be(input logic [1:0] sz, input logic [1:0] ln);
        int n;
        n = 1 << sz;
        return 4'(((1 << n) - 1) << ln);
    endfunction

    function automatic logic [31:0] mdl_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = 1 << sz;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [1:0] sz, input logic sg,
                                             input logic [1:0] ln, input logic [31:0] rd);
        longint unsigned v, m;
        int n;
        n = 1 << sz;
        if (n >= 4) return rd;
        m = (64'd1 << (8 * n)) - 1;
        v = (64'(rd) >> (8 * ln)) & m;
        if (sg && v[8*n-1]) v = v | ~m;
        return v[31:0];
    endfunction

    // ---------------- per-cycle comparator ----------------
    always @(negedge clk) begin
        if (u_if.req_valid && u_if.req_ready) acc_cyc = cyc;
        if (u_if.rsp_valid) last_lat = cyc - acc_cyc + 1;
        if (chk_en) begin
            check("req_ready", 32'(u_if.req_ready), 32'(m_ready));
            check("bus_req",   32'(u_if.bus_req),   32'(m_bus_req));
            check("stall",     32'(u_if.stall),     32'((u_if.req_valid && !m_ready) || m_bus_req));
            check("rsp_valid", 32'(u_if.rsp_valid), 32'(m_rsp));
            check("rsp_rdata", u_if.rsp_rdata, m_hold);
            check("exc_adel",  32'(u_if.exc_adel),  32'(m_exl));
            check("exc_ades",  32'(u_if.exc_ades),  32'(m_exs));
            if (m_bus_req) begin
                check("bus_addr",  u_if.bus_addr,  m_addr);
                check("bus_be",    32'(u_if.bus_be), 32'(m_be));
                check("bus_we",    32'(u_if.bus_we), 32'(m_we));
                if (m_we) check("bus_wdata", u_if.bus_wdata, m_wdata);
            end
        end
    end

    // ---------------- driver ----------------
    // dly >= 0: ack after dly wait cycles; dly < 0: never ack (timeout build).
    task automatic do_op(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int dly, input logic junk,
                         input logic chk_lit, input logic [31:0] lit_a,
                         input logic [3:0] lit_be, input logic [31:0] lit_d);
        int n, exp_lat;
        logic al;
        logic [31:0] res;
        n  = 1 << sz;
        al = (sz != 2'b11) && ((addr % n) == 0);
        exp_lat = !al ? 2 : (dly < 0 ? 2 + TO : 3 + dly);

        u_if.req_valid  = 1'b1;
        u_if.req_we     = we;
        u_if.req_size   = sz;
        u_if.req_signed = sg;
        u_if.req_addr   = addr;
        u_if.req_wdata  = wdata;
        @(posedge clk); #1;
        m_ready = 1'b0;
        if (junk) begin
            // A competing request while busy must be ignored.
            u_if.req_addr  = 32'hFFFF_FFF1;
            u_if.req_wdata = ~wdata;
            u_if.req_we    = ~we;
        end else begin
            u_if.req_valid = 1'b0;
        end
        if (al) begin
            m_bus_req = 1'b1;
            m_we      = we;
            m_addr    = {addr[31:2], 2'b00};
            m_be      = mdl_be(sz, addr[1:0]);
            m_wdata   = mdl_wdata(sz, wdata);
            if (chk_lit) begin
                check("lit_bus_addr", u_if.bus_addr, lit_a);
                check("lit_bus_be",   32'(u_if.bus_be), 32'(lit_be));
                if (we) check("lit_bus_wdata", u_if.bus_wdata, lit_d);
            end
            if (dly < 0) begin
                repeat (TO) begin @(posedge clk); #1; end
                u_if.req_valid = 1'b0;
                res   = 32'd0;
                m_exl = !we;
                m_exs = we;
            end else begin
                for (int i = 0; i < dly; i++) begin @(posedge clk); #1; end
                u_if.bus_ack   = 1'b1;
                u_if.bus_rdata = rdata;
                u_if.req_valid = 1'b0;
                @(posedge clk); #1;
                u_if.bus_ack   = 1'b0;
                u_if.bus_rdata = $urandom;
                res = we ? 32'd0 : mdl_load(sz, sg, addr[1:0], rdata);
            end
            m_bus_req = 1'b0;
        end else begin
            res   = 32'd0;
            m_exl = !we;
            m_exs = we;
        end
        m_rsp  = 1'b1;
        m_hold = res;
        if (chk_lit && (!we || !al)) check("lit_rsp_rdata", u_if.rsp_rdata, lit_d);
        @(negedge clk); #1;
        check("latency", 32'(last_lat), 32'(exp_lat));
        @(posedge clk); #1;
        m_rsp   = 1'b0;
        m_exl   = 1'b0;
        m_exs   = 1'b0;
        m_ready = 1'b1;
    endtask

    logic [31:0] lb_exp [4];

    initial begin
        lb_exp[0] = 32'h0000_0001;
        lb_exp[1] = 32'h0000_007F;
        lb_exp[2] = 32'hFFFF_FFFF;
        lb_exp[3] = 32'hFFFF_FF80;

        u_if.req_valid  = 1'b0;
        u_if.req_we     = 1'b0;
        u_if.req_size   = 2'b00;
        u_if.req_signed = 1'b0;
        u_if.req_addr   = 32'd0;
        u_if.req_wdata  = 32'd0;
        u_if.bus_ack    = 1'b0;
        u_if.bus_rdata  = 32'd0;
        chk_en    = 1'b0;
        m_ready   = 1'b1;
        m_bus_req = 1'b0;
        m_rsp     = 1'b0;
        m_exl     = 1'b0;
        m_exs     = 1'b0;
        m_we      = 1'b0;
        m_addr    = 32'd0;
        m_wdata   = 32'd0;
        m_be      = 4'd0;
        m_hold    = 32'd0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(u_if.req_ready), 32'd1);
        check("rst_bus_req",   32'(u_if.bus_req),   32'd0);
        check("rst_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
        check("rst_stall",     32'(u_if.stall),     32'd0);
        check("rst_rsp_rdata", u_if.rsp_rdata,      32'd0);
        check("rst_bus_be",    32'(u_if.bus_be),    32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Store byte at lane 3
        do_op(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 1'b0,
              1'b1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5);
        // Halfword loads, signed and unsigned
        do_op(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1'b0,
              1'b1, 32'h0000_2000, 4'b1100, 32'hFFFF_8001);
        do_op(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, 1'b0,
              1'b1, 32'h0000_2000, 4'b1100, 32'h0000_8001);
        // Signed byte loads across all lanes
        for (int i = 0; i < 4; i++) begin
            logic [3:0] be_l;
            be_l = 4'b0001 << i;
            do_op(1'b0, 2'b00, 1'b1, 32'h0000_0100 + 32'(i), 32'h0, 32'h80FF_7F01, 0, 1'b0,
                  1'b1, 32'h0000_0100, be_l, lb_exp[i]);
        end
        // Misaligned word load and half store
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0, 32'h0, 0, 1'b0,
              1'b1, 32'h0, 4'h0, 32'h0);
        do_op(1'b1, 2'b01, 1'b0, 32'h0000_3001, 32'h1234_5678, 32'h0, 0, 1'b0,
              1'b1, 32'h0, 4'h0, 32'h0);
        // Reserved size is treated as misaligned
        do_op(1'b0, 2'b11, 1'b0, 32'h0000_8000, 32'h0, 32'h0, 0, 1'b0,
              1'b0, 32'h0, 4'h0, 32'h0);
        // Word store with a long ack delay and a competing request held meanwhile
        do_op(1'b1, 2'b10, 1'b0, 32'h0000_5004, 32'h1234_5678, 32'h0, LONG_DLY, 1'b1,
              1'b1, 32'h0000_5004, 4'b1111, 32'h1234_5678);
        // Half store to upper lanes
        do_op(1'b1, 2'b01, 1'b0, 32'h0000_6002, 32'hCAFE_BEEF, 32'h0, 2, 1'b0,
              1'b1, 32'h0000_6000, 4'b1100, 32'hBEEF_BEEF);
        // Word load, sign flag must not matter
        do_op(1'b0, 2'b10, 1'b1, 32'h0000_7000, 32'h0, 32'hDEAD_BEEF, 1, 1'b0,
              1'b1, 32'h0000_7000, 4'b1111, 32'hDEAD_BEEF);

        // Reset in the middle of a transfer; a late ack must be ignored
        u_if.req_valid  = 1'b1;
        u_if.req_we     = 1'b0;
        u_if.req_size   = 2'b10;
        u_if.req_signed = 1'b0;
        u_if.req_addr   = 32'h0000_4000;
        @(posedge clk); #1;
        u_if.req_valid = 1'b0;
        m_ready   = 1'b0;
        m_bus_req = 1'b1;
        m_we      = 1'b0;
        m_addr    = 32'h0000_4000;
        m_be      = 4'b1111;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        m_ready   = 1'b1;
        m_bus_req = 1'b0;
        m_hold    = 32'd0;
        check("midrst_bus_req", 32'(u_if.bus_req), 32'd0);
        u_if.bus_ack   = 1'b1;
        u_if.bus_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        u_if.bus_ack = 1'b0;
        check("late_ack_rsp", 32'(u_if.rsp_valid), 32'd0);
        @(posedge clk); #1;

        // Port still works after the abort
        do_op(1'b0, 2'b00, 1'b0, 32'h0000_0902, 32'h0, 32'h00C3_0000, 0, 1'b0,
              1'b1, 32'h0000_0900, 4'b0100, 32'h0000_00C3);

`ifdef LSU_TIMEOUT_EN
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_A000, 32'h0, 32'h0, -1, 1'b0,
              1'b1, 32'h0000_A000, 4'b1111, 32'h0);
        do_op(1'b1, 2'b00, 1'b0, 32'h0000_A001, 32'h0000_0077, 32'h0, -1, 1'b0,
              1'b1, 32'h0000_A000, 4'b0010, 32'h7777_7777);
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_bus_port.md
Name: lsu_bus_port

Overview:
- Load/store port between the M pipeline stage and the external data bus (DM/bridge).
- Store path narrows outgoing data: byte/half lane placement plus byte enables.
- Load path extracts the addressed lane from returned bus data and sign- or zero-extends it to 32 bits for the W stage.
- Runs a registered request/acknowledge handshake and stalls the pipeline while a transfer is in flight.

Parameters:
- TIMEOUT_CYCLES, 255: ack-wait limit before bus-error abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  M stage presents a memory op
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as misaligned)
- req_signed  in  1  load sign-extend (lb/lh) vs zero-extend (lbu/lhu); ignored for stores and words
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_ready  out  1  high in IDLE only; request accepted when req_valid && req_ready
- stall  out  1  (req_valid && !req_ready) || state==REQ
- bus_req  out  1  bus transfer request, held until ack
- bus_we  out  1  bus write
- bus_addr  out  32  word address (bits[1:0]=00)
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-placed store data
- bus_ack  in  1  bus completion; bus_rdata valid same cycle
- bus_rdata  in  32  bus read word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load result (0 for stores and exceptions)
- exc_adel  out  1  load address error, qualified by rsp_valid
- exc_ades  out  1  store address error, qualified by rsp_valid

Behaviour:
- Reset: state=IDLE. All outputs 0 except req_ready=1.
- States: IDLE, REQ, RSP.
  - IDLE --accept, aligned--> REQ. Latch bus_addr={addr[31:2],2'b00}, bus_we, bus_be, bus_wdata, lane=addr[1:0], size, signed.
  - IDLE --accept, misaligned--> RSP. No bus activity. Flag exc_adel (load) or exc_ades (store).
  - REQ: bus_req=1, with addr/be/wdata stable. On bus_ack: capture the extended result into rsp_rdata, go to RSP.
  - RSP: rsp_valid=1 for exactly one cycle, then IDLE.
- Latency: minimum 3 cycles from accept to rsp_valid (accept, ack in first REQ cycle, RSP).
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00; byte is always aligned.
- Byte enables: byte = 4'b0001<<lane; half = 4'b0011<<lane; word = 4'b1111.
- Store data: byte replicated to all 4 lanes; half replicated to both halves; word passed unchanged.
- Load extract:
  - byte = rdata[8*lane+7 -: 8]
  - half = rdata[8*lane+15 -: 16]
  - extend per req_signed; word unchanged.
- rsp_rdata holds its value until the next capture. It is cleared on exceptions and stores.
- New requests are ignored outside IDLE (req_ready=0); the M stage holds via stall.
- bus_ack outside REQ is ignored.
- Reset mid-transfer forces IDLE and drops bus_req the next cycle. A late bus_ack is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: an 8+ bit counter clears on entering REQ and increments each REQ cycle without ack. Reaching TIMEOUT_CYCLES forces RSP, asserts exc_adel/exc_ades per op, sets rsp_rdata=0 and drops bus_req.
- Undefined: no counter; REQ waits indefinitely.

Decomposition:
- Shared package: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state encodings, exception codes.
- One sub-module: lsu_lane_ext (combinational lane extract + sign/zero extend), reusable by the W stage.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000A5 -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x1000; ack next cycle -> rsp_valid 3 cycles after accept.
- Signed load half: addr=0x2002, rdata=0x8001_1234 -> rsp_rdata=0xFFFF8001; with req_signed=0 -> 0x00008001.
- Load byte, lanes 0..3 of rdata=0x80FF7F01, signed -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
- Misaligned lw at 0x3002 -> no bus_req, rsp_valid with exc_adel=1 two cycles after accept; sh at 0x3001 -> exc_ades=1.
- Ack delayed 5 cycles: bus_req/addr/be stable, stall=1 throughout, exactly one rsp_valid. Reset asserted in REQ -> bus_req=0 next cycle and a subsequent ack produces no rsp_valid.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4: no ack -> RSP after 4 REQ cycles with exc flag and rsp_rdata=0.
